alu_accumulator: RTL and testbench

- Sequential accumulator stage wrapped around the existing combinational 8-bit adder/subtractor.
- Holds the accumulator (operand A), captures an incoming operand and opcode over a valid/ready handshake, and drives the adder from registered values.
- Writes back the sum and the carry/zero flags, then presents the result over a second valid/ready handshake to downstream control.

---
 rtl/alu_acc_pkg.sv | 22 ++
 rtl/add_sub_8bit.sv | 29 ++
 rtl/alu_accumulator.sv | 111 +++++++++++
 tb/tb_alu_accumulator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_acc_pkg.sv
// ---------------------------------------------------------------------------
// alu_acc_pkg
// Shared definitions for the accumulator stage.
//   op_code_t : operation encodings carried on op_code
//   state_t   : control FSM state encodings (2-bit)
// ---------------------------------------------------------------------------
package alu_acc_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CMP  = 2'b11
    } op_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/add_sub_8bit.sv
// ---------------------------------------------------------------------------
// add_sub_8bit
// Combinational 8-bit adder/subtractor.
//   op_a, op_b : operands
//   sub        : 1 = op_a - op_b (two's complement), 0 = op_a + op_b
//   sum        : 8-bit result, modulo 256
//   carry_out  : carry out of bit 7; for subtraction 1 means no borrow
//   res_zero   : sum == 0
// ---------------------------------------------------------------------------
module add_sub_8bit (
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    input  logic       sub,
    output logic [7:0] sum,
    output logic       carry_out,
    output logic       res_zero
);

    logic [7:0] b_eff;
    logic [8:0] total;

    // Subtraction is op_a + ~op_b + 1, so the carry-in is the sub bit itself.
    assign b_eff     = sub ? ~op_b : op_b;
    assign total     = {1'b0, op_a} + {1'b0, b_eff} + {8'h00, sub};
    assign sum       = total[7:0];
    assign carry_out = total[8];
    assign res_zero  = (total[7:0] == 8'h00);

endmodule

// File: rtl/alu_accumulator.sv
// ---------------------------------------------------------------------------
// alu_accumulator
// Sequential accumulator stage around add_sub_8bit.
//   clk, rst              : clock, synchronous active-high reset
//   op_valid/op_ready     : command handshake (op_code, op_data)
//   op_code               : 00 LOAD, 01 ADD, 10 SUB, 11 CMP
//   op_data               : operand B or load value
//   res_valid/res_ready   : result handshake
//   acc                   : accumulator register
//   flag_carry, flag_zero : flag registers
//
// Handshake semantics (both channels): a transfer happens at a rising edge
// where valid and ready are both high. op_ready is high only in IDLE and
// res_valid only in DONE; both are decoded from the state register alone,
// so neither depends combinationally on op_valid or res_ready. Once raised,
// res_valid stays high with acc/flags stable until res_ready is seen.
//
// The FSM state is held in the internal signal 'state' (state_t) so checkers
// can observe it hierarchically.
// ---------------------------------------------------------------------------
module alu_accumulator
    import alu_acc_pkg::*;
#(
    parameter logic [7:0] RESET_ACC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [1:0] op_code,
    input  logic [7:0] op_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] acc,
    output logic       flag_carry,
    output logic       flag_zero
);

    state_t     state;
    logic [7:0] b_reg;
    op_code_t   op_reg;

    logic       sub;
    logic [7:0] sum;
    logic       carry_out;
    logic       res_zero;

    // The adder only runs off registered values, so its inputs are stable
    // for the whole EXEC cycle.
    assign sub = (op_reg == OP_SUB) || (op_reg == OP_CMP);

    add_sub_8bit u_add_sub (
        .op_a      (acc),
        .op_b      (b_reg),
        .sub       (sub),
        .sum       (sum),
        .carry_out (carry_out),
        .res_zero  (res_zero)
    );

    assign op_ready  = (state == ST_IDLE);
    assign res_valid = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            acc        <= RESET_ACC;
            flag_carry <= 1'b0;
            flag_zero  <= 1'b0;
            b_reg      <= 8'h00;
            op_reg     <= OP_LOAD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        b_reg  <= op_data;
                        op_reg <= op_code_t'(op_code);
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Only write-back point for acc and the flags.
                    case (op_reg)
                        OP_LOAD: begin
                            acc        <= b_reg;
                            flag_carry <= 1'b0;
                            flag_zero  <= (b_reg == 8'h00);
                        end
                        OP_ADD, OP_SUB: begin
                            acc        <= sum;
                            flag_carry <= carry_out;
                            flag_zero  <= res_zero;
                        end
                        OP_CMP: begin
                            flag_carry <= carry_out;
                            flag_zero  <= res_zero;
                        end
                    endcase
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_accumulator.sv
// ---------------------------------------------------------------------------
// tb_alu_accumulator
// Self-checking bench for alu_accumulator. Inputs are driven and outputs
// sampled on the falling edge; expected {acc, carry, zero} values are pushed
// when a command is driven and popped when res_valid is observed.
// ---------------------------------------------------------------------------
module tb_alu_accumulator;
    import alu_acc_pkg::*;

    localparam logic [7:0] RESET_ACC = 8'h00;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [1:0] op_code;
    logic [7:0] op_data;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] acc;
    logic       flag_carry;
    logic       flag_zero;

    always #5 clk = ~clk;

    alu_accumulator #(.RESET_ACC(RESET_ACC)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_data    (op_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .acc        (acc),
        .flag_carry (flag_carry),
        .flag_zero  (flag_zero)
    );

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q[$];   // {acc, carry, zero}
    int         n_checks = 0;
    int         n_errors = 0;

    logic [7:0] m_acc;
    logic       m_carry;
    logic       m_zero;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: arithmetic done with 9-bit unsigned math.
    task automatic model_step(input logic [1:0] code, input logic [7:0] data);
        logic [8:0] t;
        case (code)
            2'b00: begin
                m_acc   = data;
                m_carry = 1'b0;
                m_zero  = (data == 8'h00);
            end
            2'b01: begin
                t       = {1'b0, m_acc} + {1'b0, data};
                m_acc   = t[7:0];
                m_carry = t[8];
                m_zero  = (t[7:0] == 8'h00);
            end
            default: begin
                t       = {1'b0, m_acc} - {1'b0, data};
                m_carry = (m_acc >= data);
                m_zero  = (t[7:0] == 8'h00);
                if (code == 2'b10) m_acc = t[7:0];
            end
        endcase
    endtask

    // ---------------- driver ----------------
    // One full command: accept, observe result, optional backpressure of
    // 'hold' cycles with ignored op_valid pulses, then return to IDLE.
    task automatic do_op(input logic [1:0] code, input logic [7:0] data, input int hold);
        int         lat;
        logic [9:0] exp;
        @(negedge clk);
        check("idle_op_ready", op_ready, 1);
        op_valid  = 1'b1;
        op_code   = code;
        op_data   = data;
        res_ready = (hold == 0);
        model_step(code, data);
        exp_q.push_back({m_acc, m_carry, m_zero});
        @(negedge clk);
        // EXEC: inputs changed here must be ignored.
        op_valid = 1'b0;
        op_code  = 2'($urandom_range(0, 3));
        op_data  = 8'($urandom_range(0, 255));
        check("exec_res_valid", res_valid, 0);
        check("exec_op_ready", op_ready, 0);
        lat = 1;
        @(negedge clk);
        while (!res_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("result_latency", lat, 1);
        if (exp_q.size() == 0) begin
            check("queue_underflow", 1, 0);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check("res_acc", acc, exp[9:2]);
        check("res_carry", flag_carry, exp[1]);
        check("res_zero", flag_zero, exp[0]);
        for (int i = 0; i < hold; i++) begin
            op_valid = 1'b1;
            op_code  = OP_ADD;
            op_data  = 8'hAA;
            @(negedge clk);
            check("bp_res_valid", res_valid, 1);
            check("bp_op_ready", op_ready, 0);
            check("bp_acc", acc, exp[9:2]);
            check("bp_flags", {flag_carry, flag_zero}, exp[1:0]);
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        if (hold > 0) @(negedge clk);
        @(negedge clk);
        check("ret_res_valid", res_valid, 0);
        check("ret_op_ready", op_ready, 1);
        check("ret_acc", acc, exp[9:2]);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_acc"}, acc, RESET_ACC);
        check({tag, "_carry"}, flag_carry, 0);
        check({tag, "_zero"}, flag_zero, 0);
        check({tag, "_op_ready"}, op_ready, 1);
        check({tag, "_res_valid"}, res_valid, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        op_valid  = 1'b0;
        op_code   = 2'b00;
        op_data   = 8'h00;
        res_ready = 1'b1;
        m_acc     = RESET_ACC;
        m_carry   = 1'b0;
        m_zero    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // LOAD then ADD with overflow
        do_op(OP_LOAD, 8'hFF, 0);
        do_op(OP_ADD, 8'h01, 0);
        check("ovf_acc", acc, 8'h00);
        check("ovf_flags", {flag_carry, flag_zero}, 2'b11);

        // SUB with and without borrow
        do_op(OP_LOAD, 8'h05, 0);
        do_op(OP_SUB, 8'h03, 0);
        check("sub_nb", {acc, flag_carry, flag_zero}, {8'h02, 2'b10});
        do_op(OP_SUB, 8'h05, 0);
        check("sub_b", {acc, flag_carry, flag_zero}, {8'hFD, 2'b00});

        // CMP leaves acc untouched
        do_op(OP_LOAD, 8'h3C, 0);
        do_op(OP_CMP, 8'h3C, 0);
        check("cmp_eq", {acc, flag_carry, flag_zero}, {8'h3C, 2'b11});
        do_op(OP_CMP, 8'h40, 0);
        check("cmp_lt", {acc, flag_carry, flag_zero}, {8'h3C, 2'b00});

        // Backpressure
        do_op(OP_LOAD, 8'h20, 0);
        do_op(OP_ADD, 8'h10, 5);
        check("bp_final_acc", acc, 8'h30);

        // Reset mid-operation
        do_op(OP_LOAD, 8'h01, 0);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = OP_ADD;
        op_data  = 8'h07;
        @(negedge clk);
        op_valid = 1'b0;
        check("mid_exec_res_valid", res_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("mid_rst");
        check("mid_rst_no_wb", (acc == 8'h08), 0);
        m_acc   = RESET_ACC;
        m_carry = 1'b0;
        m_zero  = 1'b0;
        @(negedge clk);
        check("mid_rst_settled_acc", acc, RESET_ACC);

        // Random commands with random backpressure
        for (int i = 0; i < 24; i++) begin
            do_op(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), $urandom_range(0, 2));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
